// File: rtl/dm_bist_pkg.sv
// Shared types, default constants and pattern generator for the dm BIST initiator.
// Latency: n/a (package only).
// Backpressure: n/a.
package dm_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ      = 3'd2,
        S_WRITE_INV = 3'd3,
        S_READ_INV  = 3'd4,
        S_DRAIN     = 3'd5,
        S_DONE      = 3'd6
    } bist_state_t;

    localparam int          DEF_ADDR_W    = 7;
    localparam int          DEF_DATA_W    = 32;
    localparam int          DEF_DEPTH     = 128;
    localparam int          DEF_RD_LAT    = 1;
    localparam logic [63:0] DEF_SEED      = 64'd0;
    localparam logic [63:0] DEF_DATA_STEP = 64'd10;

    // Pattern arithmetic is done at this width and truncated by the caller,
    // which gives the required mod 2^DATA_W wrap for any DATA_W up to 64.
    localparam int          PAT_W         = 64;
    localparam logic [7:0]  ERR_MAX       = 8'hFF;

    // P(a) = seed + a*step, optionally inverted.
    function automatic logic [PAT_W-1:0] bist_pattern(
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] step,
        input logic [PAT_W-1:0] a,
        input logic             inv
    );
        logic [PAT_W-1:0] p;
        p = seed + a * step;
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/dm_bist_cmp.sv
// Read-data checker: delays {valid, expected, addr} by RD_LAT, compares against rdata, counts errors.
// Latency: compare happens RD_LAT+1 edges after the read strobe register is loaded (registered strobe + RD_LAT).
// Backpressure: none; accepts one entry per cycle, never stalls.
module dm_bist_cmp
    import dm_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_exp,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [7:0]        o_err_count,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [DATA_W-1:0] o_fail_data,
    output logic              o_err_zero_nxt
);

    logic              r_vld  [RD_LAT];
    logic [DATA_W-1:0] r_exp  [RD_LAT];
    logic [ADDR_W-1:0] r_addr [RD_LAT];

    logic [7:0]        r_err;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;

    logic              w_hit;
    logic [7:0]        w_err_nxt;

    // Delay line: the oldest stage lines up with the rdata belonging to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_vld[k]  <= 1'b0;
                r_exp[k]  <= '0;
                r_addr[k] <= '0;
            end
        end else if (i_clr) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_vld[k]  <= 1'b0;
                r_exp[k]  <= '0;
                r_addr[k] <= '0;
            end
        end else begin
            r_vld[0]  <= i_vld;
            r_exp[0]  <= i_exp;
            r_addr[0] <= i_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_exp[k]  <= r_exp[k-1];
                r_addr[k] <= r_addr[k-1];
            end
        end
    end

    assign w_hit = r_vld[RD_LAT-1] && (i_rdata != r_exp[RD_LAT-1]);

    // Next error count, saturating; exposed so the top can register pass on the final edge.
    always_comb begin
        w_err_nxt = r_err;
        if (i_clr) begin
            w_err_nxt = '0;
        end else if (w_hit && (r_err != ERR_MAX)) begin
            w_err_nxt = r_err + 8'd1;
        end
    end

    // Error counter plus first-fail capture; a zero count means no earlier mismatch this run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err       <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_err <= w_err_nxt;
            if (i_clr) begin
                r_fail_addr <= '0;
                r_fail_data <= '0;
            end else if (w_hit && (r_err == 8'd0)) begin
                r_fail_addr <= r_addr[RD_LAT-1];
                r_fail_data <= i_rdata;
            end
        end
    end

    assign o_err_count    = r_err;
    assign o_fail_addr    = r_fail_addr;
    assign o_fail_data    = r_fail_data;
    assign o_err_zero_nxt = (w_err_nxt == 8'd0);

endmodule

// File: rtl/dm_bist.sv
// March BIST for dm: write P, read/compare P, write ~P, read/compare ~P, then report pass/err/first fail.
// Latency: outputs change on the edge that samples start; busy lasts 4*DEPTH+RD_LAT cycles.
// Backpressure: none; dm is assumed to accept one access per cycle, start while busy is ignored.
module dm_bist
    import dm_bist_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = DEF_DEPTH,
    parameter int                RD_LAT    = DEF_RD_LAT,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(DEF_SEED),
    parameter logic [DATA_W-1:0] DATA_STEP = DATA_W'(DEF_DATA_STEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    // One counter serves both the address sweep and the drain wait.
    localparam int               CNT_MAX    = (DEPTH > RD_LAT) ? DEPTH : RD_LAT;
    localparam int               CNT_W      = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(RD_LAT - 1);

    bist_state_t       r_state;
    bist_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_start_acc;

    logic              w_wr_nxt;
    logic              w_rd_nxt;
    logic              w_inv_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_pat_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [DATA_W-1:0] w_exp_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_zero_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic              r_rd;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_exp;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    // FSM state and sweep counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, and the access the registered outputs will present next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_WRITE;
                    w_cnt_nxt   = '0;
                    w_start_acc = 1'b1;
                end
            end
            S_WRITE, S_READ, S_WRITE_INV, S_READ_INV: begin
                if (r_cnt == LAST_ADDR) begin
                    w_cnt_nxt = '0;
                    case (r_state)
                        S_WRITE:     w_state_nxt = S_READ;
                        S_READ:      w_state_nxt = S_WRITE_INV;
                        S_WRITE_INV: w_state_nxt = S_READ_INV;
                        default:     w_state_nxt = S_DRAIN;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == LAST_DRAIN) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_wr_nxt    = (w_state_nxt == S_WRITE) || (w_state_nxt == S_WRITE_INV);
        w_rd_nxt    = (w_state_nxt == S_READ)  || (w_state_nxt == S_READ_INV);
        w_inv_nxt   = (w_state_nxt == S_WRITE_INV) || (w_state_nxt == S_READ_INV);
        w_addr_nxt  = (w_wr_nxt || w_rd_nxt) ? ADDR_W'(w_cnt_nxt) : '0;
        w_pat_nxt   = DATA_W'(bist_pattern(PAT_W'(SEED), PAT_W'(DATA_STEP),
                                           PAT_W'(w_addr_nxt), w_inv_nxt));
        w_wdata_nxt = w_wr_nxt ? w_pat_nxt : '0;
        w_exp_nxt   = w_rd_nxt ? w_pat_nxt : '0;
        w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    // Registered dm strobes and status; pass samples the count including the final compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_rd    <= w_rd_nxt;
            r_wr    <= w_wr_nxt;
            r_wdata <= w_wdata_nxt;
            r_exp   <= w_exp_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_done_nxt && w_err_zero_nxt;
        end
    end

    dm_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_cmp (
        .clk            (clk),
        .rst            (rst),
        .i_clr          (w_start_acc),
        .i_vld          (r_rd),
        .i_exp          (r_exp),
        .i_addr         (r_addr),
        .i_rdata        (rdata),
        .o_err_count    (err_count),
        .o_fail_addr    (fail_addr),
        .o_fail_data    (fail_data),
        .o_err_zero_nxt (w_err_zero_nxt)
    );

    assign addr  = r_addr;
    assign rd    = r_rd;
    assign wr    = r_wr;
    assign wdata = r_wdata;
    assign busy  = r_busy;
    assign done  = r_done;
    assign pass  = r_pass;

endmodule

// File: tb/tb_dm_bist.sv
// Bench for dm_bist: two instances (default seed and wrapping seed) each beside a behavioural dm.
// Latency: dm model returns read data one cycle after the strobe.
// Backpressure: none.
module tb_dm_bist;

    localparam int          AW     = 7;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 128;
    localparam logic [31:0] SEED_B = 32'hFFFF_FFF0;
    localparam int          RUN_CY = 4 * DEPTH + 1;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic sel   = 1'b0;

    logic [AW-1:0] addr_a, addr_b, fail_addr_a, fail_addr_b;
    logic          rd_a, rd_b, wr_a, wr_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b, fail_data_a, fail_data_b;
    logic [7:0]    err_a, err_b;

    // Read faults: bits forced to 1 and bits forced to 0, per address.
    logic [DW-1:0] s1 [DEPTH];
    logic [DW-1:0] s0 [DEPTH];
    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] w100, w100i, w2, w2i;

    always #5 clk = ~clk;

    dm_bist u_dut_a (
        .clk(clk), .rst(rst), .start(start), .addr(addr_a), .rd(rd_a), .wr(wr_a),
        .wdata(wdata_a), .rdata(rdata_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_addr(fail_addr_a), .fail_data(fail_data_a)
    );

    dm_bist #(.SEED(SEED_B), .DATA_STEP(32'd10)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .addr(addr_b), .rd(rd_b), .wr(wr_b),
        .wdata(wdata_b), .rdata(rdata_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_addr(fail_addr_b), .fail_data(fail_data_b)
    );

    // Behavioural dm for each instance, read latency 1, faults applied on read.
    always @(posedge clk) begin
        if (wr_a) mem_a[addr_a] <= wdata_a;
        if (rd_a) rdata_a <= (mem_a[addr_a] | s1[addr_a]) & ~s0[addr_a];
        if (wr_b) mem_b[addr_b] <= wdata_b;
        if (rd_b) rdata_b <= (mem_b[addr_b] | s1[addr_b]) & ~s0[addr_b];
    end

    wire [AW-1:0] o_addr  = sel ? addr_b      : addr_a;
    wire          o_rd    = sel ? rd_b        : rd_a;
    wire          o_wr    = sel ? wr_b        : wr_a;
    wire [DW-1:0] o_wdata = sel ? wdata_b     : wdata_a;
    wire          o_busy  = sel ? busy_b      : busy_a;
    wire          o_done  = sel ? done_b      : done_a;
    wire          o_pass  = sel ? pass_b      : pass_a;
    wire [7:0]    o_err   = sel ? err_b       : err_a;
    wire [AW-1:0] o_faddr = sel ? fail_addr_b : fail_addr_a;
    wire [DW-1:0] o_fdata = sel ? fail_data_b : fail_data_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pat(input logic [31:0] seed, input int a, input logic inv);
        logic [31:0] p;
        p = seed + 32'(a) * 32'd10;
        return inv ? ~p : p;
    endfunction

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            s1[a] = '0;
            s0[a] = '0;
        end
    endtask

    // Expected run result: walk both read passes over the faulty memory view.
    task automatic model(input logic [31:0] seed, output int e_err,
                         output logic [31:0] e_fa, output logic [31:0] e_fd);
        logic [31:0] ex, ob;
        e_err = 0; e_fa = 0; e_fd = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                ex = pat(seed, a, ph == 1);
                ob = (ex | s1[a]) & ~s0[a];
                if (ob != ex) begin
                    if (e_err == 0) begin
                        e_fa = 32'(a);
                        e_fd = ob;
                    end
                    if (e_err < 255) e_err++;
                end
            end
        end
    endtask

    task automatic run_check(input string tag);
        logic [31:0] seed, e_fa, e_fd, ea, ed;
        int e_err, i, dev, ph, a;
        logic ewr, erd, to;
        seed = sel ? SEED_B : 32'd0;
        model(seed, e_err, e_fa, e_fd);
        dev = 0; i = 0; to = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (o_busy && !to) begin
            ph = i / DEPTH;
            a  = i % DEPTH;
            if (i < 4 * DEPTH) begin
                ewr = (ph % 2) == 0;
                erd = !ewr;
                ea  = 32'(a);
                ed  = ewr ? pat(seed, a, ph == 2) : 32'd0;
            end else begin
                ewr = 1'b0; erd = 1'b0; ea = 0; ed = 0;
            end
            if (o_wr !== ewr || o_rd !== erd || o_addr !== ea[AW-1:0] || o_wdata !== ed) dev++;
            if (i == 100)             w100  = o_wdata;
            if (i == 2 * DEPTH + 100) w100i = o_wdata;
            if (i == 2)               w2    = o_wdata;
            if (i == 2 * DEPTH + 2)   w2i   = o_wdata;
            i++;
            if (i > RUN_CY + 50) to = 1'b1;
            else @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(i), 32'(RUN_CY));
        check({tag, " schedule_deviations"}, 32'(dev), 32'd0);
        check({tag, " done"}, 32'(o_done), 32'd1);
        check({tag, " pass"}, 32'(o_pass), 32'(e_err == 0));
        check({tag, " err_count"}, 32'(o_err), 32'(e_err));
        check({tag, " fail_addr"}, 32'(o_faddr), e_fa);
        check({tag, " fail_data"}, 32'(o_fdata), e_fd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, dn, nf, fa;
        clear_faults();
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy_a), 0);
        check("reset done", 32'(done_a), 0);
        check("reset rd_wr", {30'd0, rd_a, wr_a}, 0);
        check("reset addr_wdata", 32'(addr_a) | wdata_a, 0);
        check("reset err_pass", {23'd0, pass_a, err_a}, 0);
        rst = 1'b0;

        // Clean memory
        sel = 1'b0;
        run_check("clean");
        check("clean w100", w100, 32'h3E8);
        check("clean w100_inv", w100i, ~32'h3E8);

        // Bit 0 of address 5 stuck at 1
        s1[5] = 32'd1;
        run_check("stuck5");
        check("stuck5 err_const", 32'(err_a), 1);
        check("stuck5 faddr_const", 32'(fail_addr_a), 5);
        check("stuck5 fdata_const", fail_data_a, 51);

        // rdata always 0
        clear_faults();
        for (int a = 0; a < DEPTH; a++) s0[a] = '1;
        run_check("zero");
        check("zero err_const", 32'(err_a), 255);
        check("zero faddr_const", 32'(fail_addr_a), 1);

        // Reset during READ with errors already counted
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst in_read", 32'(rd_a), 1);
        check("midrst err_nonzero", 32'(err_a != 0), 1);
        rst = 1'b1;
        #1;
        check("midrst busy_rd_wr_done", {28'd0, busy_a, rd_a, wr_a, done_a}, 0);
        check("midrst addr_wdata", 32'(addr_a) | wdata_a, 0);
        check("midrst err_faddr_fdata", 32'(err_a) | 32'(fail_addr_a) | fail_data_a, 0);
        @(negedge clk); rst = 1'b0;
        clear_faults();
        run_check("after_rst");

        // start held high through a run
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        i = 0;
        while (busy_a && i < RUN_CY + 50) begin
            i++;
            @(negedge clk);
        end
        check("held busy_cycles", 32'(i), 32'(RUN_CY));
        dn = 0;
        while (done_a && dn < 5) begin
            dn++;
            @(negedge clk);
        end
        check("held done_cycles", 32'(dn), 1);
        check("held restarted", 32'(busy_a), 1);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Wrapping seed instance
        sel = 1'b1;
        run_check("seed");
        check("seed w2", w2, 32'h0000_0004);
        check("seed w2_inv", w2i, 32'hFFFF_FFFB);

        // Random faults on either instance
        for (int r = 0; r < 6; r++) begin
            sel = 1'($urandom_range(0, 1));
            clear_faults();
            nf = $urandom_range(0, 4);
            for (int f = 0; f < nf; f++) begin
                fa = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) s1[fa] = s1[fa] | (32'd1 << $urandom_range(0, 31));
                else s0[fa] = s0[fa] | $urandom;
            end
            run_check($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dm_bist.md
# dm_bist

Synthesizable built-in self-test initiator for the data memory `dm`. On a `start` pulse it drives the `dm` port (`addr`, `rd`, `wr`, `wdata`) through a four-phase march: pattern write, pattern read/compare, inverted write, inverted read/compare. It reports pass/fail, a saturating error count and the first failing location. It sits beside `dm` in the emulation top and replaces the bench-driven write/read-back loop with hardware.

## Interface
Parameters:
- `ADDR_W`, default 7: `dm` address width.
- `DATA_W`, default 32: `dm` data width.
- `DEPTH`, default 128: words tested, addresses 0..DEPTH-1. Must satisfy DEPTH ≤ 2^ADDR_W.
- `RD_LAT`, default 1: `dm` read latency in cycles, ≥1.
- `SEED`, default 0: pattern value at address 0.
- `DATA_STEP`, default 10: pattern increment per address.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `start`, input, 1: begins a run. Sampled only in IDLE or DONE.
- `addr`, output, ADDR_W: `dm` address.
- `rd`, output, 1: `dm` read strobe.
- `wr`, output, 1: `dm` write strobe.
- `wdata`, output, DATA_W: `dm` write data.
- `rdata`, input, DATA_W: `dm` read data. Valid RD_LAT cycles after `rd`/`addr` are presented.
- `busy`, output, 1: a run is in progress.
- `done`, output, 1: run complete. Level, held until the next start.
- `pass`, output, 1: meaningful while `done`=1. Equals (err_count==0).
- `err_count`, output, 8: number of mismatches. Saturates at 255.
- `fail_addr`, output, ADDR_W: address of the first mismatch.
- `fail_data`, output, DATA_W: `rdata` observed at the first mismatch.

## Operation
- Pattern: P(a) = SEED + a·DATA_STEP, truncated to DATA_W bits (wraps mod 2^DATA_W). Inverted pattern is ~P(a).
- FSM states: IDLE → WRITE → READ → WRITE_INV → READ_INV → DRAIN → DONE.
  - IDLE or DONE with `start`=1 → WRITE. Entering WRITE clears `done`, `pass`, `err_count`, `fail_addr` and `fail_data`.
  - Each of WRITE, READ, WRITE_INV and READ_INV lasts exactly DEPTH cycles, with `addr` stepping 0..DEPTH-1. One access is issued per cycle.
  - DRAIN lasts RD_LAT cycles, then the FSM moves to DONE.
  - DONE stays in DONE until `start`.
- WRITE / WRITE_INV: `wr`=1, `rd`=0, `wdata`=P(addr) or ~P(addr).
- READ / READ_INV: `rd`=1, `wr`=0.
  - The expected value and address enter an RD_LAT-deep delay line.
  - RD_LAT cycles later, `rdata` is compared against the expected value.
  - Compares still in flight continue while the next phase starts.
- Mismatch handling:
  - `err_count` increments, saturating at 255.
  - On the first mismatch of a run, `fail_addr` and `fail_data` are captured. Later mismatches do not overwrite them.
- `rd` and `wr` are never asserted together.
- In IDLE, DRAIN and DONE: `rd`=`wr`=0, `addr`=0, `wdata`=0.
- `start` while `busy`=1 is ignored.
- Reset values: `addr`=0, `rd`=0, `wr`=0, `wdata`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_addr`=0, `fail_data`=0. FSM in IDLE, delay line empty.
- `rst` mid-run: all outputs go to their reset values immediately (asynchronously). Pending compares are discarded. `dm` contents are not touched.

## Timing
- All outputs are registered.
- `start` is sampled high at edge N. From edge N: `busy`=1, `wr`=1, `addr`=0, `wdata`=SEED.
- `dm` captures the first write at edge N+1.
- The last READ_INV read is issued in cycle N+4·DEPTH. Its compare occurs at edge N+4·DEPTH+RD_LAT.
- At that same edge: `busy`=0, `done`=1, and `pass` is valid.
- Total `busy` time: 4·DEPTH+RD_LAT cycles. This is 513 cycles at the defaults.
- A restart from DONE: `done` drops at the edge that samples `start`.

## Structure
- Package `dm_bist_pkg`:
  - state enum `bist_state_t`;
  - default parameter constants;
  - function `bist_pattern(a, inv)`.
- Sub-module `dm_bist_cmp`: RD_LAT-deep delay line of {valid, expected, addr}, plus compare, error counter and first-fail capture.
- Top-level `dm_bist`: FSM, address/data generation, and the `dm` strobes.

## Test plan
- Clean behavioural `dm` with defaults, `start` pulsed once:
  - `busy` is high for 513 cycles;
  - during WRITE, address 100 is written with 0x3E8;
  - then `done`=1, `pass`=1, `err_count`=0.
- `dm` model with bit 0 of address 5 stuck at 1:
  - READ sees 51 where 50 is expected; READ_INV matches;
  - result: `err_count`=1, `fail_addr`=5, `fail_data`=51, `pass`=0.
- `dm` model whose `rdata` is always 0:
  - mismatches at addresses 1..127 in READ and all 128 in READ_INV;
  - result: `err_count`=255 (saturated), `fail_addr`=1, `fail_data`=0.
- `rst` asserted at cycle 200 (during READ):
  - all outputs are 0 in that same cycle;
  - after release, a new `start` completes with `pass`=1 in 513 cycles.
- `start` held high for the entire run:
  - run length is unchanged (the `start` during `busy` is ignored);
  - the FSM restarts immediately after DONE, and `done` is high for exactly one cycle.
- `SEED`=0xFFFFFFF0, `DATA_STEP`=10:
  - address 2 is written with 0x00000004 (wrap-around);
  - address 2 in WRITE_INV is written with 0xFFFFFFFB;
  - `pass`=1.
